// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, NOP encoding and the fetch-stage state enum.
package cpu_pkg;

   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: one outstanding SRAM-like request, branch/flush redirect.
// Optional IF_PERF_CNT_EN adds if_stall_cnt, a count of cycles with if_stall_req high.
module if_fetch
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        refresh,
   input  logic [31:0] refresh_pc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_addr_error,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] if_stall_cnt,
`endif
   output logic        if_stall_req
);

   fetch_state_t state, state_n;
   logic [31:0]  pc, pc_n;
   logic [31:0]  buf_inst, buf_inst_n;
   logic         cancel, cancel_n;
   logic         misalign;
   logic         wait_hit;
   logic         ready;
   logic [31:0]  seq_pc;

   // Valid/ready on the bus: a request is offered while inst_req is high and is
   // accepted in the cycle inst_addr_ok is high; data returns on a later inst_data_ok.
   assign misalign = (pc[1:0] != 2'b00);
   assign wait_hit = (state == WAIT) && inst_data_ok && !cancel;
   assign ready    = (state == READY) || wait_hit;
   assign seq_pc   = br_taken ? br_target : pc + 32'd4;

   assign inst_req      = (state == REQ) && !misalign;
   assign inst_addr     = pc;
   assign if_pc         = pc;
   assign if_addr_error = misalign;
   assign if_stall_req  = !ready;

   always_comb begin
      if_inst = NOP_INST;
      if (!misalign) begin
         if (state == READY) if_inst = buf_inst;
         else if (wait_hit)  if_inst = inst_rdata;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      cancel_n   = cancel;
      buf_inst_n = buf_inst;
      if (refresh) begin
         // Flush wins; an accepted-but-unreturned request is marked for discard.
         pc_n = refresh_pc;
         case (state)
            REQ: begin
               if (inst_req && inst_addr_ok) begin
                  state_n  = WAIT;
                  cancel_n = 1'b1;
               end
            end
            WAIT: begin
               if (inst_data_ok) begin
                  state_n  = REQ;
                  cancel_n = 1'b0;
               end else begin
                  cancel_n = 1'b1;
               end
            end
            READY:   state_n = REQ;
            default: state_n = REQ;
         endcase
      end else begin
         case (state)
            REQ: begin
               if (misalign) begin
                  state_n    = READY;
                  buf_inst_n = NOP_INST;
               end else if (inst_addr_ok) begin
                  state_n = WAIT;
               end
            end
            WAIT: begin
               if (inst_data_ok) begin
                  if (cancel) begin
                     state_n  = REQ;
                     cancel_n = 1'b0;
                  end else if (!stall) begin
                     state_n = REQ;
                     pc_n    = seq_pc;
                  end else begin
                     state_n    = READY;
                     buf_inst_n = inst_rdata;
                  end
               end
            end
            READY: begin
               if (!stall) begin
                  state_n = REQ;
                  pc_n    = seq_pc;
               end
            end
            default: state_n = REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= REQ;
         pc       <= RESET_PC;
         cancel   <= 1'b0;
         buf_inst <= NOP_INST;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         cancel   <= cancel_n;
         buf_inst <= buf_inst_n;
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)             if_stall_cnt <= 32'd0;
      else if (if_stall_req) if_stall_cnt <= if_stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed + randomized bench for if_fetch; acts as the instruction bus slave and
// tracks the expected program-counter stream with plain arithmetic.
module tb_if_fetch;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        refresh;
   logic [31:0] refresh_pc;
   logic        br_taken;
   logic [31:0] br_target;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_addr_error;
   logic        if_stall_req;
`ifdef IF_PERF_CNT_EN
   logic [31:0] if_stall_cnt;
`endif

   int          n_checks;
   int          n_errors;
   logic [31:0] exp_pc;

   if_fetch dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .refresh       (refresh),
      .refresh_pc    (refresh_pc),
      .br_taken      (br_taken),
      .br_target     (br_target),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_addr_ok  (inst_addr_ok),
      .inst_data_ok  (inst_data_ok),
      .inst_rdata    (inst_rdata),
      .if_pc         (if_pc),
      .if_inst       (if_inst),
      .if_addr_error (if_addr_error),
`ifdef IF_PERF_CNT_EN
      .if_stall_cnt  (if_stall_cnt),
`endif
      .if_stall_req  (if_stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete fetch of exp_pc; the last stalled cycle is the handover.
   task automatic fetch(input int alat, input int dlat, input int nstall,
                        input logic br, input logic [31:0] tgt, input logic [31:0] data);
      for (int i = 0; i < alat; i++) begin
         settle();
         chk("req_hold", {31'd0, inst_req}, 32'd1);
         chk("addr_hold", inst_addr, exp_pc);
         chk("stall_req_req", {31'd0, if_stall_req}, 32'd1);
         step();
      end
      inst_addr_ok = 1'b1;
      settle();
      chk("req_accept", {31'd0, inst_req}, 32'd1);
      chk("addr_accept", inst_addr, exp_pc);
      step();
      inst_addr_ok = 1'b0;
      for (int i = 0; i < dlat; i++) begin
         settle();
         chk("req_in_wait", {31'd0, inst_req}, 32'd0);
         chk("stall_req_wait", {31'd0, if_stall_req}, 32'd1);
         step();
      end
      inst_data_ok = 1'b1;
      inst_rdata   = data;
      stall        = (nstall > 0);
      br_taken     = (nstall > 0) ? !br : br;
      br_target    = (nstall > 0) ? ~tgt : tgt;
      settle();
      chk("stall_req_data", {31'd0, if_stall_req}, 32'd0);
      chk("inst_fwd", if_inst, data);
      chk("pc_fwd", if_pc, exp_pc);
      chk("adderr_fwd", {31'd0, if_addr_error}, 32'd0);
      step();
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
      for (int k = 1; k <= nstall; k++) begin
         stall     = (k < nstall);
         br_taken  = (k < nstall) ? !br : br;
         br_target = (k < nstall) ? ~tgt : tgt;
         settle();
         chk("req_ready", {31'd0, inst_req}, 32'd0);
         chk("stall_req_ready", {31'd0, if_stall_req}, 32'd0);
         chk("inst_buf", if_inst, data);
         chk("pc_ready", if_pc, exp_pc);
         step();
      end
      stall    = 1'b0;
      br_taken = 1'b0;
      exp_pc   = br ? tgt : exp_pc + 32'd4;
   endtask

   initial begin
      logic [31:0] rnd_tgt;
      n_checks     = 0;
      n_errors     = 0;
      reset        = 1'b1;
      stall        = 1'b0;
      refresh      = 1'b0;
      refresh_pc   = 32'd0;
      br_taken     = 1'b0;
      br_target    = 32'd0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'd0;
      exp_pc       = 32'hBFC0_0000;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      settle();
      chk("rst_req", {31'd0, inst_req}, 32'd1);
      chk("rst_addr", inst_addr, 32'hBFC0_0000);
      chk("rst_inst", if_inst, 32'd0);
      chk("rst_adderr", {31'd0, if_addr_error}, 32'd0);
      chk("rst_stall_req", {31'd0, if_stall_req}, 32'd1);
`ifdef IF_PERF_CNT_EN
      chk("perf_rst", if_stall_cnt, 32'd0);
      repeat (5) step();
      settle();
      chk("perf_5", if_stall_cnt, 32'd5);
`endif
      step();

      // First fetch, then a 3-cycle stall, then a taken branch
      fetch(2, 0, 0, 1'b0, 32'd0, 32'h2408_0001);
      chk("next_addr_4", inst_addr, 32'hBFC0_0004);
      fetch(0, 0, 3, 1'b0, 32'd0, $urandom);
      fetch(1, 1, 0, 1'b1, 32'hBFC0_0100, $urandom);
      settle();
      chk("br_addr", inst_addr, 32'hBFC0_0100);
      step();

      // Randomized traffic
      for (int n = 0; n < 30; n++) begin
         rnd_tgt = {16'hBFC0, 14'($urandom), 2'b00};
         fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0), rnd_tgt, $urandom);
      end

      // Refresh in REQ without acceptance; then PC wrap-around
      refresh    = 1'b1;
      refresh_pc = 32'hFFFF_FFFC;
      settle();
      chk("req_under_refresh", {31'd0, inst_req}, 32'd1);
      step();
      refresh = 1'b0;
      exp_pc  = 32'hFFFF_FFFC;
      fetch(0, 0, 0, 1'b0, 32'd0, $urandom);
      chk("wrap_pc", exp_pc, 32'd0);
      fetch(1, 0, 1, 1'b0, 32'd0, $urandom);

      // Refresh while waiting, twice; returned data must be dropped
      inst_addr_ok = 1'b1;
      settle();
      chk("addr_before_flush", inst_addr, exp_pc);
      step();
      inst_addr_ok = 1'b0;
      refresh      = 1'b1;
      refresh_pc   = 32'hBFC0_0370;
      settle();
      chk("stall_req_flush", {31'd0, if_stall_req}, 32'd1);
      step();
      refresh_pc = 32'hBFC0_0380;
      step();
      refresh      = 1'b0;
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hDEAD_BEEF;
      settle();
      chk("drop_stall_req", {31'd0, if_stall_req}, 32'd1);
      chk("drop_inst", if_inst, 32'd0);
      step();
      inst_data_ok = 1'b0;
      exp_pc       = 32'hBFC0_0380;
      fetch(0, 0, 0, 1'b0, 32'd0, $urandom);

      // Refresh while READY discards the buffered instruction
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b1;
      stall        = 1'b1;
      step();
      inst_data_ok = 1'b0;
      refresh      = 1'b1;
      refresh_pc   = 32'hBFC0_0200;
      settle();
      chk("ready_before_flush", {31'd0, if_stall_req}, 32'd0);
      step();
      refresh = 1'b0;
      stall   = 1'b0;
      exp_pc  = 32'hBFC0_0200;
      settle();
      chk("flush_ready_addr", inst_addr, 32'hBFC0_0200);
      chk("flush_ready_req", {31'd0, inst_req}, 32'd1);

      // Refresh on acceptance, redirect to a misaligned PC
      inst_addr_ok = 1'b1;
      refresh      = 1'b1;
      refresh_pc   = 32'hBFC0_0382;
      step();
      inst_addr_ok = 1'b0;
      refresh      = 1'b0;
      inst_data_ok = 1'b1;
      inst_rdata   = $urandom;
      settle();
      chk("cancel_stall_req", {31'd0, if_stall_req}, 32'd1);
      step();
      inst_data_ok = 1'b0;
      settle();
      chk("mis_req", {31'd0, inst_req}, 32'd0);
      chk("mis_adderr", {31'd0, if_addr_error}, 32'd1);
      chk("mis_inst", if_inst, 32'd0);
      chk("mis_pc", if_pc, 32'hBFC0_0382);
      step();
      settle();
      chk("mis_ready", {31'd0, if_stall_req}, 32'd0);
      chk("mis_ready_adderr", {31'd0, if_addr_error}, 32'd1);
      chk("mis_ready_inst", if_inst, 32'd0);
      chk("mis_ready_req", {31'd0, inst_req}, 32'd0);
      refresh    = 1'b1;
      refresh_pc = 32'hBFC0_0000;
      step();
      refresh = 1'b0;
      exp_pc  = 32'hBFC0_0000;
      fetch(1, 2, 1, 1'b0, 32'd0, $urandom);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline. Generates the PC and drives the SRAM-like instruction bus, allowing at most one request in flight. Delivers `if_pc`, `if_inst` and `if_addr_error` to the IF/ID segment register, and raises `if_stall_req` until an instruction is available. Handles branch redirection at delay-slot handover, and flush redirection, including cancellation of an in-flight bus request.

## Interface
- `RESET_PC`, 32'hBFC0_0000: PC after reset.
- `clk` in 1: clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: global pipeline stall; the IF/ID register holds.
- `refresh` in 1: pipeline flush; redirect to `refresh_pc`.
- `refresh_pc` in 32: flush target (exception vector or ERET target).
- `br_taken` in 1: branch in ID is taken.
- `br_target` in 32: branch target from ID.
- `inst_req` out 1: bus request.
- `inst_addr` out 32: request address, equal to the PC register.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1: read data valid this cycle.
- `inst_rdata` in 32: read data.
- `if_pc` out 32: PC of the presented instruction.
- `if_inst` out 32: instruction; 0 (NOP) when not ready or on address error.
- `if_addr_error` out 1: PC is misaligned (`pc[1:0]` != 0).
- `if_stall_req` out 1: no instruction is ready. Depends only on state, `inst_data_ok` and the cancel flag, never on `stall`.

## Operation
- Registers: `pc`, `state`, `cancel`, `buf_inst`.
- States: REQ, WAIT, READY.
- REQ: `inst_req`=1 and `inst_addr`=`pc`, held stable until `inst_addr_ok`.
  - On `inst_addr_ok`, go to WAIT.
  - If `pc[1:0]` != 0: no request; go to READY with `if_addr_error`=1 and `if_inst`=0.
- WAIT: `inst_req`=0.
  - On `inst_data_ok` with `cancel`=0: capture `inst_rdata` into `buf_inst` and go to READY.
  - The same-cycle data is also forwarded combinationally, so `if_stall_req`=0 in that cycle.
- READY: present `buf_inst`; `if_stall_req`=0.
- Handover: occurs when ready && !`stall` && !`refresh`.
  - `pc` <= `br_taken` ? `br_target` : `pc`+4, and state <= REQ.
  - `br_taken` is sampled only at handover; the presented instruction is the delay slot.
- Refresh has priority over branch and handover; `pc` <= `refresh_pc` in every case.
  - In REQ without `inst_addr_ok`: drop the request; state stays REQ.
  - In REQ with `inst_addr_ok` in the same cycle: state <= WAIT and `cancel` <= 1.
  - In WAIT without `inst_data_ok`: `cancel` <= 1.
  - In WAIT with `inst_data_ok` in the same cycle: discard the data; state <= REQ.
  - In READY: discard the buffer; state <= REQ.
- Cancelled data: `inst_data_ok` with `cancel`=1 discards the data, clears `cancel`, and goes to REQ, issuing a request for the new `pc`.
- A second refresh while `cancel`=1 only reloads `pc`.
- PC arithmetic is 32-bit with wrap-around; no overflow detection.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=REQ, `cancel`=0, `buf_inst`=0.
  - `inst_req`=1 and `inst_addr`=32'hBFC0_0000 in the first cycle after reset deasserts.
  - `if_inst`=0, `if_addr_error`=0, `if_stall_req`=1.
- Best case: `addr_ok` in cycle N, `data_ok` in cycle N+1, handover at the end of N+1. The next request is issued in N+2, giving one instruction every 2 cycles.
- `inst_data_ok` is never expected in the same cycle as `inst_addr_ok`.
- Reset asserted mid-transaction: return to the reset state. The first `data_ok` afterward is ignored only if a request was still outstanding; the bus master must be reset together with this block.

## Configuration
- `IF_PERF_CNT_EN`: adds output `if_stall_cnt` (out, 32 bits) counting cycles with `if_stall_req`=1.
  - Resets to 0; wraps at 2^32.
- Without the macro: no port and no counter logic.

## Structure
- Shared package `cpu_pkg`:
  - `RESET_PC` constant (32'hBFC0_0000).
  - `NOP_INST` (32'h0).
  - Fetch-state enum (REQ, WAIT, READY).
- Single module; no sub-module needed.

## Test plan
- Reset, then `addr_ok` after 2 cycles and `data_ok` with rdata 32'h2408_0001 one cycle later → `if_pc`=BFC0_0000, `if_stall_req`=0 that cycle, next `inst_addr`=BFC0_0004.
- Ready instruction with `stall`=1 for 3 cycles → `inst_req`=0, `if_inst` held at the buffered value, PC unchanged; handover on the first `stall`=0 cycle.
- `br_taken`=1, `br_target`=BFC0_0100 at handover → next `inst_addr`=BFC0_0100.
- `refresh` with `refresh_pc`=BFC0_0380 while in WAIT → the next `data_ok` (rdata DEAD_BEEF) is dropped and never presented; the following request has addr BFC0_0380.
- `refresh` in the same cycle as `inst_addr_ok`, then redirect to 32'hBFC0_0382 → the cancelled data is discarded; no bus request is made; `if_addr_error`=1, `if_inst`=0, `if_pc`=BFC0_0382.
- With `IF_PERF_CNT_EN`: 5 waiting cycles → `if_stall_cnt`=5.
